// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between MEM/WB, the MDU result port, the hazard unit and the register-file write port.
interface rf_wb_arbiter_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          RegWrite;
    logic          MemtoReg;
    logic [31:0]   ReadMemData;
    logic [31:0]   ALUResult;
    logic [4:0]    WbDest;
    logic          mdu_valid;
    logic [4:0]    mdu_dest;
    logic [31:0]   mdu_data;
    logic          mdu_ready;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic          rf_src;
    logic          stall_req;
    logic [CW-1:0] fifo_count;

    modport master (
        output RegWrite, MemtoReg, ReadMemData, ALUResult, WbDest,
        output mdu_valid, mdu_dest, mdu_data,
        input  mdu_ready, rf_we, rf_waddr, rf_wdata, rf_src, stall_req, fifo_count
    );

    modport slave (
        input  RegWrite, MemtoReg, ReadMemData, ALUResult, WbDest,
        input  mdu_valid, mdu_dest, mdu_data,
        output mdu_ready, rf_we, rf_waddr, rf_wdata, rf_src, stall_req, fifo_count
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, MDU results queue in a
// small FIFO and drain on free cycles; a starved head raises stall_req to force a WB bubble.
module rf_wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    rf_wb_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } mdu_ent_t;

    mdu_ent_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [3:0]    age;

    logic          pipe_we;
    logic [31:0]   pipe_data;
    logic          push, pop;

    assign pipe_we   = bus.RegWrite & (bus.WbDest != 5'd0);
    assign pipe_data = bus.MemtoReg ? bus.ReadMemData : bus.ALUResult;

    // Ready looks at the pre-edge count, so a full FIFO stays not-ready on its draining cycle.
    assign bus.mdu_ready  = rst & (count < CW'(DEPTH));
    assign push           = bus.mdu_valid & bus.mdu_ready & (bus.mdu_dest != 5'd0);
    assign pop            = ~pipe_we & (count != '0);
    assign bus.fifo_count = count;
    assign bus.stall_req  = (age == 4'(MAX_WAIT));

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_src   = 1'b0;
        bus.rf_waddr = 5'd0;
        bus.rf_wdata = 32'd0;
        if (pipe_we) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = bus.WbDest;
            bus.rf_wdata = pipe_data;
        end else if (count != '0) begin
            bus.rf_we    = 1'b1;
            bus.rf_src   = 1'b1;
            bus.rf_waddr = mem[rd_ptr].dest;
            bus.rf_wdata = mem[rd_ptr].data;
        end
    end

    // Storage needs no reset: count/pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{dest: bus.mdu_dest, data: bus.mdu_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Age tracks how long the current head has been blocked by pipeline writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age <= 4'd0;
        end else if (count == '0 || pop) begin
            age <= 4'd0;
        end else if (age != 4'(MAX_WAIT)) begin
            age <= age + 4'd1;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (DEPTH=2, MAX_WAIT=4) with hand-computed expectations.
module tb_rf_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    rf_wb_arbiter_if #(.DEPTH(2)) bus ();

    rf_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here, checks follow #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic port(input string tag, input logic we, input logic src,
                        input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".we"},    32'(bus.rf_we),    32'(we));
        chk({tag, ".src"},   32'(bus.rf_src),   32'(src));
        chk({tag, ".waddr"}, 32'(bus.rf_waddr), 32'(a));
        chk({tag, ".wdata"}, bus.rf_wdata,      d);
    endtask

    task automatic mdu(input logic v, input logic [4:0] dst, input logic [31:0] d);
        bus.mdu_valid = v;
        bus.mdu_dest  = dst;
        bus.mdu_data  = d;
    endtask

    task automatic pipe(input logic rw, input logic [4:0] dst);
        bus.RegWrite = rw;
        bus.WbDest   = dst;
    endtask

    initial begin
        bus.RegWrite = 1'b0; bus.MemtoReg = 1'b0; bus.ReadMemData = '0;
        bus.ALUResult = '0; bus.WbDest = '0;
        mdu(1'b0, 5'd0, 32'd0);

        // Reset state
        #2;
        chk("rst.count", 32'(bus.fifo_count), 32'd0);
        chk("rst.stall", 32'(bus.stall_req),  32'd0);
        chk("rst.ready", 32'(bus.mdu_ready),  32'd0);
        port("rst.port", 1'b0, 1'b0, 5'd0, 32'd0);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("rel.ready", 32'(bus.mdu_ready), 32'd1);

        // Pipeline write passes straight through
        tick();
        pipe(1'b1, 5'd5);
        bus.MemtoReg = 1'b1; bus.ReadMemData = 32'hDEADBEEF; bus.ALUResult = 32'h0000_0011;
        #1;
        port("pipe.load", 1'b1, 1'b0, 5'd5, 32'hDEADBEEF);
        chk("pipe.count", 32'(bus.fifo_count), 32'd0);
        bus.MemtoReg = 1'b0;
        #1;
        port("pipe.alu", 1'b1, 1'b0, 5'd5, 32'h0000_0011);

        // Idle pipeline: MDU result written the cycle after acceptance
        tick();
        pipe(1'b0, 5'd5);
        mdu(1'b1, 5'd9, 32'h12345678);
        #1;
        port("idle.pre", 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        mdu(1'b0, 5'd0, 32'd0);
        #1;
        port("idle.mdu", 1'b1, 1'b1, 5'd9, 32'h12345678);
        chk("idle.count1", 32'(bus.fifo_count), 32'd1);
        tick();
        #1;
        chk("idle.count0", 32'(bus.fifo_count), 32'd0);
        port("idle.empty", 1'b0, 1'b0, 5'd0, 32'd0);

        // Blocked pipeline fills the FIFO; third result waits; drain in order
        pipe(1'b1, 5'd3);
        bus.ALUResult = 32'h0000_0333;
        mdu(1'b1, 5'd1, 32'hA1);
        tick();
        mdu(1'b1, 5'd2, 32'hA2);
        #1;
        chk("fill.count1", 32'(bus.fifo_count), 32'd1);
        chk("fill.ready1", 32'(bus.mdu_ready),  32'd1);
        tick();
        mdu(1'b1, 5'd3, 32'hA3);
        #1;
        chk("fill.count2", 32'(bus.fifo_count), 32'd2);
        chk("fill.full",   32'(bus.mdu_ready),  32'd0);
        port("fill.pipe", 1'b1, 1'b0, 5'd3, 32'h0000_0333);
        tick();
        #1;
        chk("fill.held", 32'(bus.fifo_count), 32'd2);
        chk("fill.nostall", 32'(bus.stall_req), 32'd0);
        pipe(1'b0, 5'd3);
        #1;
        port("drain.1", 1'b1, 1'b1, 5'd1, 32'hA1);
        chk("drain.full_ready", 32'(bus.mdu_ready), 32'd0);
        tick();
        #1;
        chk("drain.ready", 32'(bus.mdu_ready), 32'd1);
        chk("drain.count", 32'(bus.fifo_count), 32'd1);
        port("drain.2", 1'b1, 1'b1, 5'd2, 32'hA2);
        tick();
        mdu(1'b0, 5'd0, 32'd0);
        #1;
        chk("drain.pushpop", 32'(bus.fifo_count), 32'd1);
        port("drain.3", 1'b1, 1'b1, 5'd3, 32'hA3);
        tick();
        #1;
        chk("drain.done", 32'(bus.fifo_count), 32'd0);

        // Starved head raises stall_req after MAX_WAIT blocked cycles
        pipe(1'b1, 5'd4);
        bus.ALUResult = 32'h0000_0444;
        mdu(1'b1, 5'd7, 32'hB7);
        tick();
        mdu(1'b0, 5'd0, 32'd0);
        tick(); tick(); tick();
        #1;
        chk("age.3", 32'(bus.stall_req), 32'd0);
        tick();
        #1;
        chk("age.4", 32'(bus.stall_req), 32'd1);
        tick();
        #1;
        chk("age.sat", 32'(bus.stall_req), 32'd1);
        pipe(1'b0, 5'd4);
        #1;
        port("age.bubble", 1'b1, 1'b1, 5'd7, 32'hB7);
        chk("age.hold", 32'(bus.stall_req), 32'd1);
        tick();
        #1;
        chk("age.clear", 32'(bus.stall_req),  32'd0);
        chk("age.count", 32'(bus.fifo_count), 32'd0);

        // Write to $0 leaves the port to the MDU; dest 0 result is dropped
        pipe(1'b1, 5'd4);
        mdu(1'b1, 5'd6, 32'hC6);
        tick();
        pipe(1'b1, 5'd0);
        mdu(1'b1, 5'd0, 32'hFFFF_FFFF);
        #1;
        port("zero.port", 1'b1, 1'b1, 5'd6, 32'hC6);
        chk("zero.ready", 32'(bus.mdu_ready), 32'd1);
        tick();
        mdu(1'b0, 5'd0, 32'd0);
        #1;
        chk("zero.drop", 32'(bus.fifo_count), 32'd0);
        port("zero.idle", 1'b0, 1'b0, 5'd0, 32'd0);

        // Mid-cycle reset discards queued entries
        pipe(1'b1, 5'd4);
        mdu(1'b1, 5'd10, 32'hD0);
        tick();
        mdu(1'b1, 5'd11, 32'hD1);
        tick();
        mdu(1'b0, 5'd0, 32'd0);
        #1;
        chk("arst.pre", 32'(bus.fifo_count), 32'd2);
        #1;
        rst = 1'b0;
        #1;
        chk("arst.count", 32'(bus.fifo_count), 32'd0);
        chk("arst.stall", 32'(bus.stall_req),  32'd0);
        chk("arst.ready", 32'(bus.mdu_ready),  32'd0);
        port("arst.pipe", 1'b1, 1'b0, 5'd4, 32'h0000_0444);
        pipe(1'b0, 5'd0);
        #1;
        port("arst.idle", 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("arst.rel_ready", 32'(bus.mdu_ready), 32'd1);
        port("arst.nostale", 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        #1;
        port("arst.nostale2", 1'b0, 1'b0, 5'd0, 32'd0);
        chk("arst.count2", 32'(bus.fifo_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the single register-file write port between the pipeline write-back stage (MEM/WB outputs) and the multi-cycle multiply/divide unit (MDU). Pipeline writes always win. MDU results wait in a small FIFO and drain on cycles where the pipeline leaves the port free. If an MDU result waits too long, the block requests a pipeline stall from the hazard unit so that a bubble frees the port. It sits between MEM/WB, the MDU result interface and the register file write port.

## Interface
- DEPTH, 2, MDU result FIFO entries; power of two, 2..8
- MAX_WAIT, 4, cycles the FIFO head may wait before stall_req asserts; 1..15
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- RegWrite  in  1  pipeline write enable from MEM/WB
- MemtoReg  in  1  1 selects ReadMemData, 0 selects ALUResult
- ReadMemData  in  32  pipeline load data
- ALUResult  in  32  pipeline ALU result
- WbDest  in  5  pipeline destination register
- mdu_valid  in  1  MDU result valid
- mdu_dest  in  5  MDU destination register
- mdu_data  in  32  MDU result
- mdu_ready  out  1  FIFO can accept an MDU result this cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- rf_src  out  1  0 = pipeline write, 1 = MDU write
- stall_req  out  1  request to the hazard unit to insert a WB bubble
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries

## Operation
- Pipeline write active: pipe_we = RegWrite & (WbDest != 0). Writes to $0 never occupy the port.
- Pipeline write data: MemtoReg ? ReadMemData : ALUResult.
- Port grant, combinational:
  - if pipe_we: rf_we=1, rf_src=0, address and data from the pipeline.
  - else if fifo_count != 0: rf_we=1, rf_src=1, address and data from the FIFO head; the head is popped at the clock edge.
  - else: rf_we=0, rf_src=0, rf_waddr=0, rf_wdata=0.
- mdu_ready = rst & (fifo_count < DEPTH). It is evaluated on the pre-edge count, so a full FIFO is not ready even on a cycle it drains.
- Accept: on mdu_valid & mdu_ready, the result is pushed.
  - Exception: when mdu_dest == 0, the handshake completes but nothing is pushed.
- Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- Age counter (4 bits):
  - cleared when the FIFO is empty or the head pops;
  - otherwise increments each cycle the head is blocked by pipe_we;
  - saturates at MAX_WAIT.
- stall_req = (age == MAX_WAIT), a registered state decode. It stays asserted until the head pops. The hazard unit answers by presenting RegWrite=0 at WB.
- Ordering: MDU results leave in acceptance order. Pipeline writes are never delayed or reordered by this block.
- Reset (rst low, async):
  - pointers, count and age go to 0; stall_req=0; mdu_ready=0;
  - rf_we follows pipe_we only, since the FIFO is empty;
  - any in-flight FIFO contents are discarded.

## Timing
- Pipeline path: RegWrite/WbDest to rf_we/rf_waddr is combinational, 0 cycles.
- MDU path latency: accepted at edge N, written to the register file no earlier than cycle N+1, the first cycle with no pipe_we.
- stall_req rises on the edge where age reaches MAX_WAIT, i.e. MAX_WAIT blocked cycles after the entry became head. It falls on the edge that pops the head.
- Full to not-full: mdu_ready rises the cycle after a pop from a full FIFO.

## Test plan
- Reset, then RegWrite=1, WbDest=5, MemtoReg=1, ReadMemData=0xDEADBEEF -> same cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, rf_src=0; fifo_count=0.
- Idle pipeline; MDU pushes dest=9, data=0x12345678 at edge N -> cycle N+1: rf_we=1, rf_src=1, rf_waddr=9; fifo_count returns to 0 after edge N+1.
- pipe_we held high; MDU pushes 3 results with DEPTH=2 -> first two accepted, mdu_ready=0 with fifo_count=2; third held until a pop; results drain in order 1, 2, 3 when RegWrite drops.
- pipe_we held high with one entry queued, MAX_WAIT=4 -> stall_req rises after 4 blocked cycles; RegWrite=0 next cycle -> entry written, stall_req=0 after that edge.
- RegWrite=1 with WbDest=0 while an entry is queued -> rf_src=1, the MDU entry is written; MDU result with mdu_dest=0 -> handshake completes, fifo_count unchanged.
- Two entries queued, rst pulsed low mid-cycle -> immediately fifo_count=0, stall_req=0, mdu_ready=0; after release mdu_ready=1 and no stale write appears.
